// File: rtl/seq_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// 2N-bit dividend / N-bit divisor -> 2N-bit quotient, N-bit remainder.
module seq_div #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           busy,
    output logic           done,
    output logic           dbz
);

    localparam int W  = 2 * N;
    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;
    logic [N-1:0]    d_q, d_d;
    logic [N:0]      r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            dz_q, dz_d;
    logic [W-1:0]    quo_q, quo_d;
    logic [N-1:0]    rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [N:0]      r_sh;
    logic [W-1:0]    q_sh;
    logic [N+1:0]    diff;
    logic [N:0]      r_nxt;
    logic [W-1:0]    q_nxt;

    always_comb begin
        r_sh  = {r_q[N-1:0], q_q[W-1]};
        q_sh  = {q_q[W-2:0], 1'b0};
        diff  = {1'b0, r_sh} - {2'b00, d_q};
        // Sign bit of the trial subtraction decides restore vs. keep
        r_nxt = diff[N+1] ? r_sh : diff[N:0];
        q_nxt = {q_sh[W-1:1], ~diff[N+1]};
    end

    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        d_d     = d_q;
        r_d     = r_q;
        cnt_d   = cnt_q;
        dz_d    = dz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            IDLE, FIN: begin
                state_d = IDLE;
                if (start) begin
                    q_d     = dividend;
                    d_d     = divisor;
                    r_d     = '0;
                    cnt_d   = '0;
                    dz_d    = (divisor == '0);
                    dbz_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dz_q) begin
                    // Zero divisor: publish saturated result after one busy cycle
                    quo_d   = '1;
                    rem_d   = q_q[N-1:0];
                    dbz_d   = 1'b1;
                    state_d = FIN;
                end else begin
                    q_d   = q_nxt;
                    r_d   = r_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(W - 1)) begin
                        quo_d   = q_nxt;
                        rem_d   = r_nxt[N-1:0];
                        state_d = FIN;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            q_q     <= '0;
            d_q     <= '0;
            r_q     <= '0;
            cnt_q   <= '0;
            dz_q    <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            d_q     <= d_d;
            r_q     <= r_d;
            cnt_q   <= cnt_d;
            dz_q    <= dz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign busy      = (state_q == RUN);
    assign done      = (state_q == FIN);

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div (N=4): directed vectors plus a
// back-to-back sweep of every nonzero-divisor pair.
module tb_seq_div;

    localparam int N = 4;

    typedef struct {
        logic [2*N-1:0] q;
        logic [N-1:0]   r;
        logic           z;
        int             edge_no;
        int             blen;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           busy;
    logic           done;
    logic           dbz;

    exp_t sb[$];
    int   cyc    = 0;
    int   bcnt   = 0;
    int   checks = 0;
    int   errors = 0;

    seq_div #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .quotient  (quotient),
        .remainder (remainder),
        .busy      (busy),
        .done      (done),
        .dbz       (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on every done pulse
    always begin
        exp_t e;
        @(negedge clk or negedge rst_n);
        #1;
        if (!rst_n) begin
            checks++;
            if (quotient !== '0 || remainder !== '0 || busy !== 1'b0 ||
                done !== 1'b0 || dbz !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                         quotient, remainder, busy, done, dbz);
            end
            sb.delete();
            bcnt = 0;
        end else begin
            if (busy === 1'b1) bcnt++;
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 at edge %0d, want no done", cyc);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (quotient !== e.q) begin
                        errors++;
                        $display("FAIL quotient: got %0d, want %0d", quotient, e.q);
                    end
                    checks++;
                    if (remainder !== e.r) begin
                        errors++;
                        $display("FAIL remainder: got %0d, want %0d", remainder, e.r);
                    end
                    checks++;
                    if (dbz !== e.z) begin
                        errors++;
                        $display("FAIL dbz: got %b, want %b", dbz, e.z);
                    end
                    checks++;
                    if (cyc != e.edge_no) begin
                        errors++;
                        $display("FAIL latency: done after edge %0d, want %0d", cyc, e.edge_no);
                    end
                    checks++;
                    if (bcnt != e.blen) begin
                        errors++;
                        $display("FAIL busy_len: got %0d cycles, want %0d", bcnt, e.blen);
                    end
                end
                bcnt = 0;
            end
        end
    end

    // Drive start for one cycle; push the expected result if accepted
    task automatic issue(input logic [2*N-1:0] a, input logic [N-1:0] b,
                         input logic [2*N-1:0] eq, input logic [N-1:0] er,
                         input logic ez, input bit accept);
        exp_t e;
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        if (accept) begin
            e.q       = eq;
            e.r       = er;
            e.z       = ez;
            e.blen    = ez ? 1 : 2 * N;
            e.edge_no = cyc + 1 + e.blen;
            sb.push_back(e);
        end
        @(negedge clk);
        start    = 1'b0;
        dividend = ~a;
        divisor  = ~b;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (done === 1'b1) return;
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no done within 40 cycles, want done");
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
        wait_done();
        issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 1'b1);
        wait_done();
        issue(8'hA7, 4'd0, 8'hFF, 4'd7, 1'b1, 1'b1);
        wait_done();
        issue(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 1'b1);
        wait_done();
        issue(8'd0, 4'd15, 8'd0, 4'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);
        @(negedge clk);

        issue(8'd100, 4'd3, 8'd33, 4'd1, 1'b0, 1'b1);
        @(negedge clk);
        issue(8'd50, 4'd5, 8'd0, 4'd0, 1'b0, 1'b0);
        wait_done();
        issue(8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 1'b1);
        wait_done();
        @(negedge clk);

        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 1'b1);
        wait_done();

        for (int a = 0; a < 256; a++) begin
            for (int b = 1; b < 16; b++) begin
                issue(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 1'b1);
                wait_done();
            end
        end
        repeat (3) @(negedge clk);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
